// File: rtl/pwm_capture_pkg.sv
// Shared types and constants for the PWM capture block.
package pwm_capture_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  // All-ones value of a w-bit counter (w = 32 wraps to all ones as well).
  function automatic logic [31:0] cnt_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for an asynchronous input, plus one delay flop for edge detection.
module sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pwm_in,
  output logic pwm_s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pwm_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      pwm_d  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      pwm_d  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pwm_s = sync_q[SYNC_STAGES-1];
  assign rise  = pwm_s & ~pwm_d;
  assign fall  = ~pwm_s & pwm_d;

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of an incoming PWM waveform, rising edge to rising edge,
// and flags an input that has stopped toggling.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int unsigned W           = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         pwm_in,
  output logic [W-1:0] period,
  output logic [W-1:0] high_time,
  output logic         valid,
  output logic         timeout,
  output logic         stuck_level
);

  localparam logic [W-1:0] CNT_MAX = W'(cnt_max(W));

  logic         pwm_s;
  logic         rise;
  logic         fall;
  logic [W-1:0] cnt;
  logic [W-1:0] hi_lat;
  state_t       state;

  sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk   (clk),
    .rst   (rst),
    .pwm_in(pwm_in),
    .pwm_s (pwm_s),
    .rise  (rise),
    .fall  (fall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      hi_lat      <= '0;
      period      <= '0;
      high_time   <= '0;
      valid       <= 1'b0;
      timeout     <= 1'b0;
      stuck_level <= 1'b0;
    end else if (!en) begin
      state   <= IDLE;
      cnt     <= '0;
      hi_lat  <= '0;
      valid   <= 1'b0;
      timeout <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (rise) begin
        cnt     <= W'(1);
        timeout <= 1'b0;
        state   <= HIGH;
        // A saturated count cannot be trusted as a period, so it is not published.
        if (state == LOW && cnt != CNT_MAX) begin
          period    <= cnt;
          high_time <= hi_lat;
          valid     <= 1'b1;
        end
      end else if (cnt == CNT_MAX) begin
        state <= IDLE;
        // Keep the level seen when the timeout first fired, not later wiggles.
        if (!timeout) begin
          timeout     <= 1'b1;
          stuck_level <= pwm_s;
        end
      end else begin
        cnt <= cnt + W'(1);
        if (state == HIGH && fall) begin
          hi_lat <= cnt;
          state  <= LOW;
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: table of PWM shapes plus hand-written reset/enable/timeout sequences.
module tb_pwm_capture;

  localparam int unsigned SYNC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        pwm16;
  logic        pwm8;
  logic [15:0] period16, high16;
  logic        valid16, timeout16, stuck16;
  logic [7:0]  period8, high8;
  logic        valid8, timeout8, stuck8;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int vq_per[$];
  int vq_hi[$];
  int vq_cyc[$];

  always #5 clk = ~clk;

  pwm_capture #(.W(16), .SYNC_STAGES(SYNC)) dut16 (
    .clk(clk), .rst(rst), .en(en), .pwm_in(pwm16),
    .period(period16), .high_time(high16), .valid(valid16),
    .timeout(timeout16), .stuck_level(stuck16)
  );

  pwm_capture #(.W(8), .SYNC_STAGES(SYNC)) dut8 (
    .clk(clk), .rst(rst), .en(en), .pwm_in(pwm8),
    .period(period8), .high_time(high8), .valid(valid8),
    .timeout(timeout8), .stuck_level(stuck8)
  );

  typedef struct {
    int hi;
    int lo;
    int n;
    int exp_period;
    int exp_high;
    int exp_valids;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock of stimulus: sample outputs settled since the last posedge, then drive pwm16.
  task automatic tick(input logic lvl);
    @(negedge clk);
    cyc++;
    if (valid16 === 1'b1) begin
      vq_per.push_back(int'(period16));
      vq_hi.push_back(int'(high16));
      vq_cyc.push_back(cyc);
    end
    pwm16 = lvl;
  endtask

  task automatic clear_q();
    vq_per.delete();
    vq_hi.delete();
    vq_cyc.delete();
  endtask

  task automatic run_wave(input int hi, input int lo, input int n);
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < hi; i++) tick(1'b1);
      for (int i = 0; i < lo; i++) tick(1'b0);
    end
  endtask

  task automatic restart();
    en = 1'b0;
    repeat (3) tick(1'b0);
    en = 1'b1;
    clear_q();
  endtask

  task automatic tail();
    repeat (8) tick(1'b0);
  endtask

  task automatic check_vec(input string tag, input int exp_per, input int exp_hi,
                           input int exp_n, input int spacing);
    int bad_val;
    int bad_gap;
    bad_val = 0;
    bad_gap = 0;
    for (int i = 0; i < vq_per.size(); i++) begin
      if (vq_per[i] != exp_per || vq_hi[i] != exp_hi) bad_val++;
      if (i > 0 && (vq_cyc[i] - vq_cyc[i-1]) != spacing) bad_gap++;
    end
    check({tag, "_valid_count"}, vq_per.size(), exp_n);
    check({tag, "_bad_values"}, bad_val, 0);
    check({tag, "_bad_spacing"}, bad_gap, 0);
    check({tag, "_period"}, period16, exp_per);
    check({tag, "_high_time"}, high16, exp_hi);
  endtask

  initial begin
    int first;
    int clr;
    int v8;

    vecs[0] = '{hi: 25, lo: 75, n: 5, exp_period: 100, exp_high: 25, exp_valids: 4};
    vecs[1] = '{hi: 1,  lo: 1,  n: 6, exp_period: 2,   exp_high: 1,  exp_valids: 5};
    vecs[2] = '{hi: 1,  lo: 9,  n: 4, exp_period: 10,  exp_high: 1,  exp_valids: 3};
    vecs[3] = '{hi: 3,  lo: 5,  n: 4, exp_period: 8,   exp_high: 3,  exp_valids: 3};
    vecs[4] = '{hi: 40, lo: 60, n: 3, exp_period: 100, exp_high: 40, exp_valids: 2};

    rst   = 1'b0;
    en    = 1'b0;
    pwm16 = 1'b0;
    pwm8  = 1'b0;

    // Reset before the first clock edge: outputs must clear asynchronously.
    #2 rst = 1'b1;
    #1;
    check("rst_period", period16, 0);
    check("rst_high_time", high16, 0);
    check("rst_valid", valid16, 0);
    check("rst_timeout", timeout16, 0);
    check("rst_stuck", stuck16, 0);
    check("rst_timeout8", timeout8, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;

    // W=8: one rise, then held high until timeout.
    @(negedge clk);
    pwm8  = 1'b1;
    first = 0;
    v8    = 0;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk);
      #1;
      if (valid8 === 1'b1) v8++;
      if (timeout8 === 1'b1 && first == 0) first = n;
    end
    check("timeout_latency", first, SYNC + 256);
    check("timeout_stuck_level", stuck8, 1);
    check("timeout_no_valid", v8, 0);

    // Fall is ignored after timeout; the next rise clears it.
    @(negedge clk);
    pwm8 = 1'b0;
    repeat (4) @(negedge clk);
    check("timeout_hold_after_fall", timeout8, 1);
    pwm8 = 1'b1;
    clr  = 0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      #1;
      if (valid8 === 1'b1) v8++;
      if (timeout8 === 1'b0 && clr == 0) clr = n;
    end
    check("timeout_clear_latency", clr, SYNC + 1);
    check("timeout_clear_no_valid", v8, 0);

    for (int v = 0; v < 5; v++) begin
      restart();
      run_wave(vecs[v].hi, vecs[v].lo, vecs[v].n);
      tail();
      check_vec($sformatf("vec%0d", v), vecs[v].exp_period, vecs[v].exp_high,
                vecs[v].exp_valids, vecs[v].hi + vecs[v].lo);
    end

    // Duty change on the fly: 25/75 then 75/25 with no gap.
    restart();
    run_wave(25, 75, 3);
    run_wave(75, 25, 3);
    tail();
    check("duty_count", vq_per.size(), 5);
    if (vq_per.size() == 5) begin
      check("duty_last_old", vq_hi[2], 25);
      check("duty_first_new", vq_hi[3], 75);
      check("duty_second_new", vq_hi[4], 75);
      check("duty_period", vq_per[3], 100);
    end

    // Enable dropped for 50 clocks during the low phase of a period.
    restart();
    run_wave(25, 75, 2);
    for (int i = 0; i < 100; i++) begin
      en = (i >= 30 && i < 80) ? 1'b0 : 1'b1;
      tick(i < 25);
      if (i == 79) begin
        check("en_low_valid_count", vq_per.size(), 2);
        check("en_low_period_hold", period16, 100);
        check("en_low_high_hold", high16, 25);
      end
    end
    run_wave(40, 60, 2);
    tail();
    check("en_resume_count", vq_per.size(), 3);
    check("en_resume_period", period16, 100);
    check("en_resume_high", high16, 40);

    // Reset asserted mid-high, then 100/40 resumes.
    restart();
    run_wave(25, 75, 2);
    repeat (10) tick(1'b1);
    #2 rst = 1'b1;
    #1;
    check("midrst_period", period16, 0);
    check("midrst_high_time", high16, 0);
    check("midrst_valid", valid16, 0);
    repeat (3) tick(1'b0);
    rst = 1'b0;
    clear_q();
    run_wave(40, 60, 3);
    tail();
    check_vec("post_rst", 100, 40, 2, 100);

    // Input stuck low since enable: W=8 instance must time out at level 0.
    pwm8 = 1'b0;
    en   = 1'b0;
    tick(1'b0);
    en = 1'b1;
    repeat (270) tick(1'b0);
    check("stuck_low_timeout", timeout8, 1);
    check("stuck_low_level", stuck8, 0);
    check("w16_no_timeout", timeout16, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
